pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed per-stage IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake instead of separate write-enable and stall wiring. It supports a synchronous flush, and optionally a two-entry skid buffer so that `in_ready` is fully registered. One instance sits at each stage boundary; the payload struct is packed into `in_data`.

## Interface
Parameters:
- `WIDTH`, default 32: payload width in bits (≥1).
- `SKID_EN`, default 1: 1 selects a two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: discard all held entries and any input accepted this cycle.
- `in_valid`, input, 1: upstream payload valid.
- `in_ready`, output, 1: stage can accept; transfer occurs when `in_valid & in_ready`.
- `in_data`, input, WIDTH: upstream payload.
- `out_valid`, output, 1: payload presented downstream.
- `out_ready`, input, 1: downstream accepts; transfer occurs when `out_valid & out_ready`.
- `out_data`, output, WIDTH: payload; equals the main entry.
- `occupancy`, output, 2: number of held entries (0..2; max 1 when `SKID_EN=0`).

## Operation
- State: main entry (`m_v`, `m_d`); when `SKID_EN=1`, also skid entry (`s_v`, `s_d`). Invariant: `s_v` implies `m_v`.
- `out_valid = m_v`, `out_data = m_d`, `occupancy = m_v + s_v`.
- Define `acc = in_valid & in_ready` and `pop = m_v & out_ready`.
- SKID_EN=1:
  - `in_ready = ~s_v`, a register output with no combinational path from `out_ready`.
  - pop with `s_v`: main ← skid. If acc, skid ← in; otherwise `s_v` ← 0.
  - pop without `s_v`: if acc, main ← in; otherwise `m_v` ← 0.
  - No pop with `m_v`: if acc, skid ← in.
  - No pop with `~m_v`: if acc, main ← in.
- SKID_EN=0:
  - `in_ready = ~m_v | out_ready`.
  - If acc, main ← in (`m_v` ← 1). Else if pop, `m_v` ← 0.
- Ordering is strict FIFO; no payload is duplicated or reordered.
- Flush, when `rst=0`: the next state is `m_v = s_v = 0`. Payload accepted in the flush cycle is dropped. `in_ready` keeps its normal value during flush, so upstream sees the transfer as consumed. A downstream pop in the flush cycle still counts for the downstream side. Data registers are not cleared by flush.
- Reset: `m_v = s_v = 0`; `m_d = s_d = 0`. Reset overrides flush.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `occupancy=0`.
  - `in_ready=1` in both modes (main entry empty).
- Latency: input accepted at edge N appears on `out_data` / `out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 transfer per cycle with `out_ready` held high, in both modes.
- SKID_EN=1 backpressure:
  - When `out_ready` deasserts, at most one further beat is absorbed into the skid entry.
  - `in_ready` drops the cycle after the skid entry fills.
  - `in_ready` returns the cycle after the first pop.
- Full (`occupancy=2`) with simultaneous pop and `in_valid`: `in_ready=0`, so nothing is accepted. Next state is `occupancy=1`, skid moved to main.
- Empty with `out_ready=1` and `in_valid=1`: the payload is registered; there is no combinational bypass.
- Flush during full: after the edge, `occupancy=0` and `in_ready=1`.
- Reset asserted mid-transfer: all state is cleared next cycle, regardless of handshakes.

## Test plan
- Reset then stream, SKID_EN=1, WIDTH=32: `out_ready=1`, feed 0x1..0x8 back-to-back. Required: `out_data` shows 0x1..0x8 on consecutive cycles, each one cycle after acceptance, with `in_ready` constantly 1.
- Backpressure, SKID_EN=1: stream 0xA0, 0xA1, 0xA2…, then drop `out_ready` for 4 cycles.
  - `occupancy` reaches 2 and `in_ready` falls to 0.
  - `out_data` holds 0xA0 while stalled.
  - After release, the sequence continues with no loss or duplication.
- Full plus simultaneous pop: `occupancy=2` (0x11 main, 0x22 skid), `in_valid=1` with 0x33, `out_ready=1` for one cycle.
  - 0x11 pops and 0x33 is not accepted.
  - Next cycle: `out_data=0x22`, `occupancy=1`, `in_ready=1`.
- Flush: `occupancy=2`, assert `flush` for one cycle with `in_valid=1` and data 0x55.
  - Next cycle: `out_valid=0`, `occupancy=0`, `in_ready=1`.
  - 0x55 never appears at the output.
- SKID_EN=0, WIDTH=8:
  - With `out_valid=1` and `out_ready=0`: `in_ready=0`.
  - Raising `out_ready` with `in_valid=1` (0x7F) gives `in_ready=1` in the same cycle, and 0x7F is output next cycle.
- Reset priority: assert `rst` and `flush` together while full. Required: all outputs return to their reset values next cycle, including `out_data=0`.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Purpose: valid/ready pipeline stage register with optional two-entry skid buffer and synchronous flush.
// Latency: 1 cycle from acceptance to out_valid/out_data; no combinational input-to-output bypass.
// Backpressure: SKID_EN=1 gives registered in_ready (absorbs one extra beat); SKID_EN=0 passes out_ready through to in_ready.
module pipe_stage_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             m_v_q, m_v_d;
    logic             s_v_q, s_v_d;
    logic [WIDTH-1:0] m_d_q, m_d_d;
    logic [WIDTH-1:0] s_d_q, s_d_d;
    logic             acc;
    logic             pop;

    // With the skid entry present, in_ready comes straight off a flop so that
    // out_ready never reaches the upstream stage combinationally.
    assign in_ready  = SKID_EN ? ~s_v_q : (~m_v_q | out_ready);
    assign out_valid = m_v_q;
    assign out_data  = m_d_q;
    assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};

    assign acc = in_valid & in_ready;
    assign pop = m_v_q & out_ready;

    always_comb begin
        m_v_d = m_v_q;
        m_d_d = m_d_q;
        s_v_d = s_v_q;
        s_d_d = s_d_q;
        if (SKID_EN) begin
            if (pop && s_v_q) begin
                m_d_d = s_d_q;
                if (acc) begin
                    s_d_d = in_data;
                end else begin
                    s_v_d = 1'b0;
                end
            end else if (pop) begin
                if (acc) begin
                    m_d_d = in_data;
                end else begin
                    m_v_d = 1'b0;
                end
            end else if (m_v_q) begin
                if (acc) begin
                    s_v_d = 1'b1;
                    s_d_d = in_data;
                end
            end else if (acc) begin
                m_v_d = 1'b1;
                m_d_d = in_data;
            end
        end else begin
            if (acc) begin
                m_v_d = 1'b1;
                m_d_d = in_data;
            end else if (pop) begin
                m_v_d = 1'b0;
            end
        end
        // Flush drops valids only; stale payload bits are harmless behind a clear valid.
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
            m_d_q <= '0;
            s_d_q <= '0;
        end else begin
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
            m_d_q <= m_d_d;
            s_d_q <= s_d_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid instance (WIDTH=32) and single-entry instance (WIDTH=8)
// checked every cycle against queue models, plus directed literal expectations.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // skid instance
    logic        sk_flush = 1'b0, sk_in_valid = 1'b0, sk_out_ready = 1'b0;
    logic [31:0] sk_in_data = '0;
    logic        sk_in_ready, sk_out_valid;
    logic [31:0] sk_out_data;
    logic [1:0]  sk_occ;

    // single-entry instance
    logic        ns_flush = 1'b0, ns_in_valid = 1'b0, ns_out_ready = 1'b0;
    logic [7:0]  ns_in_data = '0;
    logic        ns_in_ready, ns_out_valid;
    logic [7:0]  ns_out_data;
    logic [1:0]  ns_occ;

    pipe_stage_reg #(.WIDTH(32), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(sk_flush),
        .in_valid(sk_in_valid), .in_ready(sk_in_ready), .in_data(sk_in_data),
        .out_valid(sk_out_valid), .out_ready(sk_out_ready), .out_data(sk_out_data),
        .occupancy(sk_occ)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .flush(ns_flush),
        .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data),
        .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
        .occupancy(ns_occ)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Models: the stage is a FIFO of capacity 2 (skid) or 1 (single entry).
    logic [31:0] q_sk[$];
    logic [7:0]  q_ns[$];
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit acc_m, pop_m;
        if (rst) begin
            q_sk.delete();
            q_ns.delete();
            started = 1'b1;
        end else begin
            acc_m = sk_in_valid && (q_sk.size() < 2);
            pop_m = (q_sk.size() > 0) && sk_out_ready;
            if (pop_m) void'(q_sk.pop_front());
            if (acc_m) q_sk.push_back(sk_in_data);
            if (sk_flush) q_sk.delete();

            acc_m = ns_in_valid && ((q_ns.size() == 0) || ns_out_ready);
            pop_m = (q_ns.size() > 0) && ns_out_ready;
            if (pop_m) void'(q_ns.pop_front());
            if (acc_m) q_ns.push_back(ns_in_data);
            if (ns_flush) q_ns.delete();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("sk_model_in_ready", 32'(sk_in_ready), 32'(q_sk.size() < 2));
            chk("sk_model_out_valid", 32'(sk_out_valid), 32'(q_sk.size() > 0));
            chk("sk_model_occupancy", 32'(sk_occ), 32'(q_sk.size()));
            if (q_sk.size() > 0) chk("sk_model_out_data", sk_out_data, q_sk[0]);
            chk("ns_model_in_ready", 32'(ns_in_ready), 32'((q_ns.size() == 0) || ns_out_ready));
            chk("ns_model_out_valid", 32'(ns_out_valid), 32'(q_ns.size() > 0));
            chk("ns_model_occupancy", 32'(ns_occ), 32'(q_ns.size()));
            if (q_ns.size() > 0) chk("ns_model_out_data", 32'(ns_out_data), 32'(q_ns[0]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sk_drive(input logic v, input logic [31:0] d, input logic ordy);
        sk_in_valid  = v;
        sk_in_data   = d;
        sk_out_ready = ordy;
    endtask

    initial begin
        // reset
        tick; tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sk_out_valid", 32'(sk_out_valid), 32'd0);
        chk("rst_sk_out_data", sk_out_data, 32'd0);
        chk("rst_sk_occ", 32'(sk_occ), 32'd0);
        chk("rst_sk_in_ready", 32'(sk_in_ready), 32'd1);
        chk("rst_ns_in_ready", 32'(ns_in_ready), 32'd1);
        chk("rst_ns_out_data", 32'(ns_out_data), 32'd0);
        tick;

        // back-to-back stream 1..8
        for (int i = 1; i <= 8; i++) begin
            sk_drive(1'b1, 32'(i), 1'b1);
            @(negedge clk);
            chk("stream_in_ready", 32'(sk_in_ready), 32'd1);
            if (i > 1) chk("stream_out_data", sk_out_data, 32'(i - 1));
            tick;
        end
        sk_drive(1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("stream_last", sk_out_data, 32'd8);
        tick;

        // backpressure
        sk_drive(1'b1, 32'hA0, 1'b1);
        tick;
        sk_drive(1'b1, 32'hA1, 1'b0);
        tick;
        sk_drive(1'b1, 32'hA2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_occ", 32'(sk_occ), 32'd2);
            chk("bp_in_ready", 32'(sk_in_ready), 32'd0);
            chk("bp_hold", sk_out_data, 32'hA0);
            tick;
        end
        sk_drive(1'b1, 32'hA2, 1'b1);
        tick;
        @(negedge clk);
        chk("bp_rel_data", sk_out_data, 32'hA1);
        chk("bp_rel_ready", 32'(sk_in_ready), 32'd1);
        chk("bp_rel_occ", 32'(sk_occ), 32'd1);
        tick;
        sk_drive(1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("bp_next", sk_out_data, 32'hA2);
        tick; tick;

        // full plus simultaneous pop
        sk_drive(1'b1, 32'h11, 1'b0);
        tick;
        sk_drive(1'b1, 32'h22, 1'b0);
        tick;
        sk_drive(1'b1, 32'h33, 1'b1);
        @(negedge clk);
        chk("fp_in_ready", 32'(sk_in_ready), 32'd0);
        chk("fp_out_data", sk_out_data, 32'h11);
        tick;
        sk_drive(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("fp_next_data", sk_out_data, 32'h22);
        chk("fp_next_occ", 32'(sk_occ), 32'd1);
        chk("fp_next_ready", 32'(sk_in_ready), 32'd1);
        sk_drive(1'b0, 32'd0, 1'b1);
        tick;
        @(negedge clk);
        chk("fp_no_33", 32'(sk_out_valid), 32'd0);
        tick;

        // flush while full, with a beat offered
        sk_drive(1'b1, 32'h66, 1'b0); tick;
        sk_drive(1'b1, 32'h77, 1'b0); tick;
        sk_drive(1'b1, 32'h55, 1'b0);
        sk_flush = 1'b1;
        tick;
        sk_flush = 1'b0;
        sk_drive(1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("fl_out_valid", 32'(sk_out_valid), 32'd0);
        chk("fl_occ", 32'(sk_occ), 32'd0);
        chk("fl_in_ready", 32'(sk_in_ready), 32'd1);
        tick; tick;
        @(negedge clk);
        chk("fl_no_55", 32'(sk_out_valid), 32'd0);

        // flush drops a beat accepted in the same cycle
        sk_drive(1'b1, 32'h56, 1'b0);
        sk_flush = 1'b1;
        @(negedge clk);
        chk("fl_acc_ready", 32'(sk_in_ready), 32'd1);
        tick;
        sk_flush = 1'b0;
        sk_drive(1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("fl_acc_drop", 32'(sk_occ), 32'd0);
        tick;

        // reset overrides flush while full
        sk_drive(1'b1, 32'h88, 1'b0); tick;
        sk_drive(1'b1, 32'h99, 1'b0); tick;
        sk_drive(1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        sk_flush = 1'b1;
        tick;
        rst = 1'b0;
        sk_flush = 1'b0;
        @(negedge clk);
        chk("rp_out_valid", 32'(sk_out_valid), 32'd0);
        chk("rp_out_data", sk_out_data, 32'd0);
        chk("rp_occ", 32'(sk_occ), 32'd0);
        chk("rp_in_ready", 32'(sk_in_ready), 32'd1);
        tick;

        // single-entry: combinational in_ready
        ns_in_valid = 1'b1; ns_in_data = 8'h10; ns_out_ready = 1'b0;
        tick;
        ns_in_data = 8'h7F;
        @(negedge clk);
        chk("ns_stall_valid", 32'(ns_out_valid), 32'd1);
        chk("ns_stall_ready", 32'(ns_in_ready), 32'd0);
        #1;
        ns_out_ready = 1'b1;
        #1;
        chk("ns_comb_ready", 32'(ns_in_ready), 32'd1);
        tick;
        ns_in_valid = 1'b0;
        ns_out_ready = 1'b0;
        @(negedge clk);
        chk("ns_7f_out", 32'(ns_out_data), 32'h7F);
        chk("ns_7f_occ", 32'(ns_occ), 32'd1);
        ns_out_ready = 1'b1;
        tick;
        @(negedge clk);
        chk("ns_drained", 32'(ns_out_valid), 32'd0);
        tick;

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            sk_in_valid  = ($urandom_range(0, 9) < 7);
            sk_out_ready = ($urandom_range(0, 9) < 6);
            sk_in_data   = $urandom;
            sk_flush     = ($urandom_range(0, 99) < 3);
            ns_in_valid  = ($urandom_range(0, 9) < 6);
            ns_out_ready = ($urandom_range(0, 9) < 5);
            ns_in_data   = 8'($urandom);
            ns_flush     = ($urandom_range(0, 99) < 3);
            rst          = ($urandom_range(0, 199) == 0);
            tick;
        end
        rst = 1'b0;
        sk_flush = 1'b0;
        ns_flush = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
